multi_channel_tick: RTL and testbench
=====================================

// Module: multi_channel_tick
// PURPOSE
//  N-channel edge-to-pulse generator: each channel turns a selected edge of a slow level
//  input (button, status flag, handshake level) into a fixed-width tick, then ignores further edges for a holdoff.
//  Per-channel edge-mode select and sticky overrun flag for edges lost while busy.
//  Sits between raw control/status levels and counters/FSMs that need one event per edge.
// PARAMETERS
//  N_CH     4  number of independent channels (>=1)
//  PULSE_W  1  tick width in clk cycles (>=1)
//  HOLDOFF  0  dead cycles after pulse before re-arming (>=0; 0 = re-arm immediately)
// PORTS
//  clk      in   1       clock; all state updates on rising edge
//  reset    in   1       asynchronous, active-high reset
//  in       in   N_CH    level inputs, bit i = channel i
//  mode     in   2*N_CH  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  clr_ovr  in   1       synchronous clear of all ovr bits
//  tick     out  N_CH    pulse outputs, high PULSE_W cycles per accepted edge
//  ovr      out  N_CH    sticky: qualifying edge seen while channel not IDLE
// BEHAVIOUR
//  - Reset: all channels IDLE, prev-sample reg = 0, counters = 0, tick = 0, ovr = 0.
//  - Edge detect per channel: rise = s & ~s_q, fall = ~s & s_q (s = sampled input, s_q = previous sample).
//    Qualifying edge = edge matching mode; s_q updates every cycle in every state.
//  - Because s_q resets to 0, a channel held high through reset gives one rise event on the 1st cycle after
//    reset release (rise/both modes); a low input never gives a fall event out of reset.
//  - FSM per channel (Moore, tick = state==PULSE):
//    IDLE    : qualifying edge at clock edge k -> PULSE, cnt = PULSE_W-1; tick high from cycle k+1.
//    PULSE   : cnt==0 -> HOLD (cnt = HOLDOFF-1) if HOLDOFF>0, else IDLE; otherwise cnt--.
//    HOLD    : cnt==0 -> IDLE, otherwise cnt--.
//  - Latency: input change to tick = 1 cycle (sampled at edge k, tick in cycle k+1).
//  - Min event spacing = PULSE_W + HOLDOFF cycles. PULSE_W=1, HOLDOFF=0: back-to-back toggles in
//    both-mode give a tick every cycle with no drop.
//  - Edges in PULSE/HOLD are dropped, never queued. A qualifying edge in PULSE/HOLD sets ovr[i].
//    A level still asserted after HOLD does not retrigger.
//  - ovr: set has priority over clr_ovr in the same cycle. Clear acts on all channels.
//  - mode: sampled every cycle. A change affects only new-edge qualification; a running PULSE/HOLD
//    completes. mode=00 blocks new triggers but s_q keeps tracking.
//  - Counter width = $clog2(max(PULSE_W,HOLDOFF)+1). No wrap; count saturates at 0 by construction.
//  - Reset mid-pulse: tick drops asynchronously and the dropped pulse is not resumed.
// CONFIGURATION
//  - TICK_SYNC_EN defined: 2-flop synchronizer per channel ahead of edge detect. Flops reset to 0.
//    Input-to-tick latency = 3 cycles. Held-high-through-reset rise event appears 3 cycles after release.
//  - TICK_SYNC_EN undefined: s = in directly. Caller guarantees in is synchronous to clk. Latency 1 cycle.
// STRUCTURE
//  - Package tick_pkg: mode encodings (MODE_OFF/RISE/FALL/BOTH), state encoding
//    (ST_IDLE, ST_PULSE, ST_HOLD, 2 bits), counter-width helper function.
//  - Sub-module tick_channel: one channel (optional sync, s_q, FSM, counter, ovr flop).
//    Top does generate-for over N_CH plus mode/in slicing.
// TESTING
//  1. N_CH=4, PULSE_W=1, HOLDOFF=0, mode=rise. in[0] 0->1, held 10 cycles
//     -> tick[0] high exactly 1 cycle, 1 cycle after sampling, no repeat.
//  2. PULSE_W=3, HOLDOFF=4, mode=both. Toggle in[1] every 2 cycles for 20 cycles
//     -> tick spacing >= 7 cycles, each tick 3 cycles wide, ovr[1]=1.
//     clr_ovr pulse -> ovr[1]=0 the next cycle.
//  3. mode=fall on ch2, rise on ch3, same stimulus 0->1->0
//     -> ch3 ticks on rise only, ch2 ticks on fall only, independent timing.
//  4. in[0]=1 during reset, mode=rise -> single tick on 1st cycle after release.
//     Same with mode=fall -> no tick.
//  5. Assert reset during cycle 2 of a PULSE_W=4 pulse
//     -> tick=0 immediately, ovr=0. After release with in still high -> one new tick.
//  6. Build with TICK_SYNC_EN, repeat test 1 -> tick appears 3 cycles after input change. Width unchanged.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared definitions for the multi-channel edge-to-tick generator: edge-mode and
// channel-state encodings plus the counter sizing helper.
package tick_pkg;

   // Per-channel edge selection, two bits per channel on the mode bus
   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } tickMode_t;

   // Channel life cycle: waiting for an edge, driving the tick, dead time
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_PULSE = 2'b01,
      ST_HOLD  = 2'b10
   } tickState_t;

   // One counter serves both the pulse and the holdoff phase, so it is
   // sized for whichever of the two is longer.
   function automatic int cntWidth(input int pulseW, input int holdoff);
      int maxCount;
      maxCount = (pulseW > holdoff) ? pulseW : holdoff;
      return $clog2(maxCount + 1);
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One channel of the tick generator: optional input synchronizer (TICK_SYNC_EN),
// edge detect, pulse/holdoff FSM with shared down-counter, and sticky overrun flag.
module tick_channel
   import tick_pkg::*;
#(
   parameter int PULSE_W = 1,
   parameter int HOLDOFF = 0
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       level,
   input  logic [1:0] mode,
   input  logic       clrOvr,
   output logic       tick,
   output logic       ovr
);

   localparam int CNT_W = cntWidth(PULSE_W, HOLDOFF);
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD  = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;
   localparam bit HAS_HOLD = (HOLDOFF > 0);

   logic             sample;
   logic             sampleQ;
   logic             riseEdge;
   logic             fallEdge;
   logic             qualEdge;
   logic             armed;
   logic             accept;
   logic             lost;
   tickMode_t        edgeMode;
   tickState_t       state;
   tickState_t       stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;

`ifdef TICK_SYNC_EN
   logic syncA;
   logic syncB;

   // Two-flop synchronizer so an asynchronous level can be fed in safely;
   // both stages clear on reset, which is why a level held high through
   // reset shows up as a rise two cycles later than in the direct build.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syncA <= 1'b0;
         syncB <= 1'b0;
      end else begin
         syncA <= level;
         syncB <= syncA;
      end
   end

   assign sample = syncB;
`else
   assign sample = level;
`endif

   // Previous sample tracks the input in every state, including while the
   // channel is busy or switched off, so a re-enabled channel never sees a
   // stale edge. Clearing it on reset makes a high input look like a rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sampleQ <= 1'b0;
      end else begin
         sampleQ <= sample;
      end
   end

   assign riseEdge = sample & ~sampleQ;
   assign fallEdge = ~sample & sampleQ;
   assign edgeMode = tickMode_t'(mode);

   // Decide whether the current edge is one this channel cares about
   always_comb begin
      qualEdge = 1'b0;
      case (edgeMode)
         MODE_RISE: qualEdge = riseEdge;
         MODE_FALL: qualEdge = fallEdge;
         MODE_BOTH: qualEdge = riseEdge | fallEdge;
         default:   qualEdge = 1'b0;
      endcase
   end

   // The channel is ready for a new edge when idle, and also on the very
   // cycle it would otherwise return to idle; that keeps the minimum event
   // spacing at PULSE_W + HOLDOFF, so single-cycle ticks can run back to back.
   // Anything qualifying outside that window is dropped and counts as overrun.
   assign armed  = (state == ST_IDLE) ||
                   ((cnt == '0) && ((state == ST_HOLD) || ((state == ST_PULSE) && !HAS_HOLD)));
   assign accept = qualEdge & armed;
   assign lost   = qualEdge & ~armed;

   // Next-state logic: an accepted edge always (re)starts the pulse, otherwise
   // the counter walks the pulse and holdoff phases down to idle.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      if (accept) begin
         stateNext = ST_PULSE;
         cntNext   = PULSE_LOAD;
      end else begin
         case (state)
            ST_IDLE: begin
               stateNext = ST_IDLE;
            end
            ST_PULSE: begin
               if (cnt == '0) begin
                  if (HAS_HOLD) begin
                     stateNext = ST_HOLD;
                     cntNext   = HOLD_LOAD;
                  end else begin
                     stateNext = ST_IDLE;
                  end
               end else begin
                  cntNext = cnt - CNT_W'(1);
               end
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  stateNext = ST_IDLE;
               end else begin
                  cntNext = cnt - CNT_W'(1);
               end
            end
            default: begin
               stateNext = ST_IDLE;
               cntNext   = '0;
            end
         endcase
      end
   end

   // State and counter registers; reset abandons any pulse in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Sticky overrun: a lost edge wins over a simultaneous clear so that no
   // overrun can slip through unreported.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr <= 1'b0;
      end else if (lost) begin
         ovr <= 1'b1;
      end else if (clrOvr) begin
         ovr <= 1'b0;
      end
   end

   assign tick = (state == ST_PULSE);

endmodule

// File: rtl/multi_channel_tick.sv
// N-channel edge-to-tick generator: slices the level and mode buses and builds
// one tick_channel per bit. Define TICK_SYNC_EN to add input synchronizers.
module multi_channel_tick
   import tick_pkg::*;
#(
   parameter int N_CH    = 4,
   parameter int PULSE_W = 1,
   parameter int HOLDOFF = 0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [N_CH-1:0]   in,
   input  logic [2*N_CH-1:0] mode,
   input  logic              clr_ovr,
   output logic [N_CH-1:0]   tick,
   output logic [N_CH-1:0]   ovr
);

   // Channels are fully independent; only the overrun clear is shared
   for (genvar i = 0; i < N_CH; i++) begin : gChannel
      tick_channel #(
         .PULSE_W (PULSE_W),
         .HOLDOFF (HOLDOFF)
      ) uChannel (
         .clk    (clk),
         .reset  (reset),
         .level  (in[i]),
         .mode   (mode[2*i +: 2]),
         .clrOvr (clr_ovr),
         .tick   (tick[i]),
         .ovr    (ovr[i])
      );
   end

endmodule

// File: tb/tb_multi_channel_tick.sv
// Bench for multi_channel_tick: three instances with different pulse/holdoff
// settings share one stimulus stream and are compared against a cycle-count model.
`timescale 1ns/1ps
module tb_multi_channel_tick;

   localparam int NCH  = 4;
   localparam int NDUT = 3;
`ifdef TICK_SYNC_EN
   localparam int SYNC_DLY = 2;
`else
   localparam int SYNC_DLY = 0;
`endif
   localparam logic [7:0] M1 = 8'b01_10_00_01;
   localparam logic [7:0] M2 = 8'b01_10_00_11;

   typedef struct {
      logic [3:0] inVec;
      logic [7:0] modeVec;
      logic [3:0] expTick;
      logic [3:0] expOvr;
   } vector_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       clrOvr;
   logic [3:0] inBus;
   logic [7:0] modeBus;
   logic [3:0] tickA, ovrA, tickB, ovrB, tickC, ovrC;

   int         testsRun    = 0;
   int         testsFailed = 0;
   int         pwOf[NDUT]  = '{1, 3, 4};
   int         hoOf[NDUT]  = '{0, 4, 2};
   int         lastAccept[NDUT][NCH];
   logic [3:0] modelOvr[NDUT];
   logic [3:0] expTick[NDUT];
   logic [3:0] prevSample;
   logic [3:0] delayLine[$];
   int         cycleNum;
   vector_t    vecTable[25];

   int         lastRise;
   int         runLen;
   int         rises;
   int         highCycles;
   logic       prevHigh;

   always #5 clk = ~clk;

   multi_channel_tick #(.N_CH(4), .PULSE_W(1), .HOLDOFF(0)) dutA (
      .clk(clk), .reset(reset), .in(inBus), .mode(modeBus), .clr_ovr(clrOvr),
      .tick(tickA), .ovr(ovrA));

   multi_channel_tick #(.N_CH(4), .PULSE_W(3), .HOLDOFF(4)) dutB (
      .clk(clk), .reset(reset), .in(inBus), .mode(modeBus), .clr_ovr(clrOvr),
      .tick(tickB), .ovr(ovrB));

   multi_channel_tick #(.N_CH(4), .PULSE_W(4), .HOLDOFF(2)) dutC (
      .clk(clk), .reset(reset), .in(inBus), .mode(modeBus), .clr_ovr(clrOvr),
      .tick(tickC), .ovr(ovrC));

   // Reference model: each channel remembers the cycle of its last accepted
   // edge; a new edge is accepted once PULSE_W + HOLDOFF cycles have passed,
   // and the tick is high for the PULSE_W cycles following acceptance.
   task automatic modelReset();
      for (int d = 0; d < NDUT; d++) begin
         for (int ch = 0; ch < NCH; ch++) lastAccept[d][ch] = -1000;
         modelOvr[d] = 4'b0000;
         expTick[d]  = 4'b0000;
      end
      prevSample = 4'b0000;
      delayLine.delete();
      for (int k = 0; k < SYNC_DLY; k++) delayLine.push_back(4'b0000);
      cycleNum = 0;
   endtask

   task automatic modelStep();
      logic [3:0] s;
      logic       rise, fall, qual, setOvr;
      logic [1:0] m;
      delayLine.push_back(inBus);
      s = delayLine.pop_front();
      for (int d = 0; d < NDUT; d++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            rise   = s[ch] & ~prevSample[ch];
            fall   = ~s[ch] & prevSample[ch];
            m      = modeBus[2*ch +: 2];
            qual   = (m[0] & rise) | (m[1] & fall);
            setOvr = 1'b0;
            if (qual) begin
               if (cycleNum - lastAccept[d][ch] >= pwOf[d] + hoOf[d]) lastAccept[d][ch] = cycleNum;
               else setOvr = 1'b1;
            end
            if (setOvr) modelOvr[d][ch] = 1'b1;
            else if (clrOvr) modelOvr[d][ch] = 1'b0;
            expTick[d][ch] = ((cycleNum - lastAccept[d][ch]) < pwOf[d]);
         end
      end
      prevSample = s;
      cycleNum++;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %b expected %b (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("dutA tick", tickA, expTick[0]);
      checkOutput("dutA ovr",  ovrA,  modelOvr[0]);
      checkOutput("dutB tick", tickB, expTick[1]);
      checkOutput("dutB ovr",  ovrB,  modelOvr[1]);
      checkOutput("dutC tick", tickC, expTick[2]);
      checkOutput("dutC ovr",  ovrC,  modelOvr[2]);
   endtask

   task automatic applyStimulus(input logic [3:0] newIn, input logic [7:0] newMode, input logic newClr);
      inBus   = newIn;
      modeBus = newMode;
      clrOvr  = newClr;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      modelStep();
      #1;
      checkAll();
   endtask

   // Hold reset across a few clock edges, expecting everything quiet throughout
   task automatic holdReset();
      reset = 1'b1;
      #1;
      modelReset();
      checkAll();
      repeat (3) begin
         @(posedge clk);
         #1;
         checkAll();
      end
      reset = 1'b0;
   endtask

   // Expected outputs for instance A (PULSE_W=1, HOLDOFF=0) over a short script
   initial begin
      vecTable[0]  = '{4'b0000, M1, 4'b0000, 4'b0000};
      vecTable[1]  = '{4'b0001, M1, 4'b0001, 4'b0000};
      vecTable[2]  = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[3]  = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[4]  = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[5]  = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[6]  = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[7]  = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[8]  = '{4'b1101, M1, 4'b1000, 4'b0000};
      vecTable[9]  = '{4'b0101, M1, 4'b0000, 4'b0000};
      vecTable[10] = '{4'b0001, M1, 4'b0100, 4'b0000};
      vecTable[11] = '{4'b0011, M1, 4'b0000, 4'b0000};
      vecTable[12] = '{4'b0001, M1, 4'b0000, 4'b0000};
      vecTable[13] = '{4'b0000, M1, 4'b0000, 4'b0000};
      vecTable[14] = '{4'b0000, M1, 4'b0000, 4'b0000};
      vecTable[15] = '{4'b0000, M1, 4'b0000, 4'b0000};
      vecTable[16] = '{4'b0000, M2, 4'b0000, 4'b0000};
      vecTable[17] = '{4'b0001, M2, 4'b0001, 4'b0000};
      vecTable[18] = '{4'b0000, M2, 4'b0001, 4'b0000};
      vecTable[19] = '{4'b0001, M2, 4'b0001, 4'b0000};
      vecTable[20] = '{4'b0000, M2, 4'b0001, 4'b0000};
      vecTable[21] = '{4'b0000, M2, 4'b0000, 4'b0000};
      vecTable[22] = '{4'b0000, M2, 4'b0000, 4'b0000};
      vecTable[23] = '{4'b0000, M2, 4'b0000, 4'b0000};
      vecTable[24] = '{4'b0000, M1, 4'b0000, 4'b0000};
   end

   // Main sequence: reset, table, hand-written corner cases, then random traffic
   initial begin
      applyStimulus(4'b0000, 8'h00, 1'b0);
      #2;
      holdReset();

      for (int i = 0; i < 25; i++) begin
         int j;
         logic [3:0] wantTick, wantOvr;
         applyStimulus(vecTable[i].inVec, vecTable[i].modeVec, 1'b0);
         stepCycle();
         j = i - SYNC_DLY;
         wantTick = 4'b0000;
         wantOvr  = 4'b0000;
         if (j >= 0) begin
            wantTick = vecTable[j].expTick;
            wantOvr  = vecTable[j].expOvr;
         end
         checkOutput($sformatf("table row %0d tick", i), tickA, wantTick);
         checkOutput($sformatf("table row %0d ovr", i), ovrA, wantOvr);
      end

      applyStimulus(4'b0000, 8'b00_00_11_00, 1'b1);
      stepCycle();
      applyStimulus(4'b0000, 8'b00_00_11_00, 1'b0);
      repeat (10) stepCycle();
      lastRise = -1;
      runLen   = 0;
      rises    = 0;
      prevHigh = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (i < 20 && (i % 2) == 0) applyStimulus(inBus ^ 4'b0010, modeBus, 1'b0);
         stepCycle();
         if (tickB[1]) begin
            if (!prevHigh) begin
               if (lastRise >= 0) checkValue("ch1 tick spacing at least 7", int'((i - lastRise) >= 7), 1);
               lastRise = i;
               runLen   = 0;
               rises++;
            end
            runLen++;
         end else if (prevHigh) begin
            checkValue("ch1 tick width", runLen, 3);
         end
         prevHigh = tickB[1];
      end
      checkValue("ch1 tick count", rises, 3);
      checkValue("ch1 ovr sticky", int'(ovrB[1]), 1);
      applyStimulus(inBus, modeBus, 1'b1);
      stepCycle();
      checkValue("ch1 ovr cleared", int'(ovrB[1]), 0);
      applyStimulus(inBus, modeBus, 1'b0);

      applyStimulus(4'b0001, 8'b00_00_00_01, 1'b0);
      holdReset();
      for (int i = 0; i < 6; i++) begin
         stepCycle();
         checkValue($sformatf("held-high rise cycle %0d", i), int'(tickA[0]), int'(i == SYNC_DLY));
      end
      applyStimulus(4'b0001, 8'b00_00_00_10, 1'b0);
      holdReset();
      for (int i = 0; i < 6; i++) begin
         stepCycle();
         checkValue($sformatf("held-high fall-mode cycle %0d", i), int'(tickA[0]), 0);
      end

      applyStimulus(4'b0000, 8'b00_00_00_01, 1'b0);
      repeat (10) stepCycle();
      applyStimulus(4'b0001, 8'b00_00_00_01, 1'b0);
      for (int i = 0; i < SYNC_DLY + 2; i++) stepCycle();
      checkValue("dutC pulse running", int'(tickC[0]), 1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("mid-pulse reset tick", tickC, 4'b0000);
      checkOutput("mid-pulse reset ovr", ovrC, 4'b0000);
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      rises      = 0;
      highCycles = 0;
      prevHigh   = 1'b0;
      for (int i = 0; i < 14; i++) begin
         stepCycle();
         if (tickC[0] && !prevHigh) rises++;
         if (tickC[0]) highCycles++;
         prevHigh = tickC[0];
      end
      checkValue("post-reset tick count", rises, 1);
      checkValue("post-reset tick width", highCycles, 4);

      applyStimulus(4'b0000, 8'($urandom), 1'b0);
      for (int c = 0; c < 3000; c++) begin
         if ((c % 700) == 350) begin
            #2;
            reset = 1'b1;
            #1;
            modelReset();
            checkAll();
            @(posedge clk);
            #1;
            checkAll();
            reset = 1'b0;
         end
         applyStimulus(inBus ^ 4'($urandom & $urandom),
                       ($urandom_range(0, 31) == 0) ? 8'($urandom) : modeBus,
                       ($urandom_range(0, 15) == 0));
         stepCycle();
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
